// File: rtl/controle_irrigacao.sv
// Irrigation sequencer: picks sprinkler or drip mode, loads the preset,
// counts MM:SS down in BCD and drives the matching valve.
module controle_irrigacao #(
  parameter logic [15:0] PRESET_ASP = 16'h5100,
  parameter logic [15:0] PRESET_GOT = 16'h0300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       umSegundo,
  input  logic       iniciar,
  input  logic       cancelar,
  input  logic [1:0] umidade,
  input  logic [2:0] nivelDagua,
  output logic       aspersao,
  output logic       gotejamento,
  output logic       alarmeAgua,
  output logic       concluido,
  output logic       ocupado,
  output logic [3:0] dezenaMinuto,
  output logic [3:0] unidadeMinuto,
  output logic [3:0] dezenaSegundos,
  output logic [3:0] unidadeSegundos,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ATIVO   = 3'd2,
    PAUSA   = 3'd3,
    FIM     = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic        modo_asp, modo_asp_nx;
  logic [15:0] tempo, tempo_nx;
  logic        nivel_ok;
  logic        pedido_ok;
  logic        pedido;
  logic        ultimo;
  logic        unused_nivel;

  // The full-tank sensor is not needed by either mode.
  assign unused_nivel = nivelDagua[2];

  // Level check for the latched mode and for a start request.
  assign nivel_ok  = modo_asp ? nivelDagua[1] : nivelDagua[0];
  assign pedido    = iniciar && !umidade[1];
  assign pedido_ok = (umidade == 2'b00) ? nivelDagua[1] : nivelDagua[0];
  assign ultimo    = (tempo == 16'h0001);

  // One-second BCD decrement with the borrow chain through MM:SS.
  function automatic logic [15:0] dec_bcd(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Next state, mode latch and countdown value.
  always_comb begin
    state_nx    = state;
    modo_asp_nx = modo_asp;
    tempo_nx    = tempo;
    if (cancelar && state != OCIOSO) begin
      state_nx = OCIOSO;
      tempo_nx = '0;
    end else begin
      case (state)
        OCIOSO: begin
          if (pedido) begin
            state_nx    = CARREGA;
            modo_asp_nx = ~umidade[0];
          end
        end
        CARREGA: begin
          tempo_nx = modo_asp ? PRESET_ASP : PRESET_GOT;
          state_nx = nivel_ok ? ATIVO : PAUSA;
        end
        ATIVO: begin
          if (umSegundo) tempo_nx = dec_bcd(tempo);
          if (umSegundo && ultimo) state_nx = FIM;
          else if (!nivel_ok)      state_nx = PAUSA;
        end
        PAUSA: begin
          if (nivel_ok) state_nx = ATIVO;
        end
        FIM: begin
          state_nx = OCIOSO;
          tempo_nx = '0;
        end
        default: begin
          state_nx = OCIOSO;
          tempo_nx = '0;
        end
      endcase
    end
  end

  // State, countdown and registered valve/pulse outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= OCIOSO;
      modo_asp    <= 1'b0;
      tempo       <= '0;
      aspersao    <= 1'b0;
      gotejamento <= 1'b0;
      concluido   <= 1'b0;
    end else begin
      state       <= state_nx;
      modo_asp    <= modo_asp_nx;
      tempo       <= tempo_nx;
      aspersao    <= (state_nx == ATIVO) && modo_asp_nx;
      gotejamento <= (state_nx == ATIVO) && !modo_asp_nx;
      concluido   <= (state_nx == FIM);
    end
  end

  // Alarm covers a paused run and a start request the tank cannot serve.
  always_comb begin
    alarmeAgua = (state == PAUSA) ||
                 ((state == OCIOSO) && pedido && !pedido_ok);
  end

  assign ocupado         = (state != OCIOSO);
  assign estado          = state;
  assign dezenaMinuto    = tempo[15:12];
  assign unidadeMinuto   = tempo[11:8];
  assign dezenaSegundos  = tempo[7:4];
  assign unidadeSegundos = tempo[3:0];

endmodule

// File: tb/tb_controle_irrigacao.sv
// Bench for controle_irrigacao: seconds-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_controle_irrigacao;

  logic       clock = 1'b0;
  logic       reset;
  logic       umSegundo = 1'b0;
  logic       iniciar = 1'b0;
  logic       cancelar = 1'b0;
  logic [1:0] umidade = 2'b00;
  logic [2:0] nivelDagua = 3'b000;
  logic       aspersao, gotejamento, alarmeAgua, concluido, ocupado;
  logic [3:0] dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos;
  logic [2:0] estado;
  logic [15:0] digs;

  controle_irrigacao dut (
    .clock(clock),
    .reset(reset),
    .umSegundo(umSegundo),
    .iniciar(iniciar),
    .cancelar(cancelar),
    .umidade(umidade),
    .nivelDagua(nivelDagua),
    .aspersao(aspersao),
    .gotejamento(gotejamento),
    .alarmeAgua(alarmeAgua),
    .concluido(concluido),
    .ocupado(ocupado),
    .dezenaMinuto(dezenaMinuto),
    .unidadeMinuto(unidadeMinuto),
    .dezenaSegundos(dezenaSegundos),
    .unidadeSegundos(unidadeSegundos),
    .estado(estado)
  );

  assign digs = {dezenaMinuto, unidadeMinuto,
                 dezenaSegundos, unidadeSegundos};

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // Model: phase number, sprinkler flag, seconds left.
  int m_st = 0;
  bit m_asp = 1'b0;
  int m_secs = 0;

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    bit ok;
    if (!reset) begin
      m_st = 0;
      m_asp = 1'b0;
      m_secs = 0;
    end else begin
      ok = m_asp ? nivelDagua[1] : nivelDagua[0];
      if (cancelar && m_st != 0) begin
        m_st = 0;
        m_secs = 0;
      end else begin
        case (m_st)
          0: if (iniciar && !umidade[1]) begin
               m_asp = (umidade == 2'b00);
               m_st = 1;
             end
          1: begin
               m_secs = m_asp ? 51 * 60 : 3 * 60;
               m_st = ok ? 2 : 3;
             end
          2: begin
               if (umSegundo) m_secs = m_secs - 1;
               if (umSegundo && m_secs == 0) m_st = 4;
               else if (!ok) m_st = 3;
             end
          3: if (ok) m_st = 2;
          default: begin
               m_st = 0;
               m_secs = 0;
             end
        endcase
      end
    end
  end

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    bit rq_ok;
    bit e_alarm;
    if (chk_en) begin
      n_vec++;
      rq_ok = (umidade == 2'b00) ? nivelDagua[1] : nivelDagua[0];
      e_alarm = (m_st == 3) ||
                (m_st == 0 && iniciar && !umidade[1] && !rq_ok);
      cmp("estado", 16'(estado), 16'(m_st));
      cmp("ocupado", 16'(ocupado), 16'(m_st != 0));
      cmp("concluido", 16'(concluido), 16'(m_st == 4));
      cmp("aspersao", 16'(aspersao), 16'(m_st == 2 && m_asp));
      cmp("gotejamento", 16'(gotejamento), 16'(m_st == 2 && !m_asp));
      cmp("alarmeAgua", 16'(alarmeAgua), 16'(e_alarm));
      cmp("digits", digs, to_bcd(m_secs));
      cmp("valves_excl", 16'(aspersao & gotejamento), 16'h0);
    end
  end

  always @(negedge clock) if (concluido) pulses++;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    cmp(nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic tick();
    umSegundo = 1'b1;
    step(1);
    umSegundo = 1'b0;
    step(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input logic [1:0] u, input logic [2:0] n);
    umidade = u;
    nivelDagua = n;
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
    step(1);
  endtask

  task automatic cancel();
    cancelar = 1'b1;
    step(1);
    cancelar = 1'b0;
    step(1);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    step(2);
    chk("rst_estado", 16'(estado), 16'h0);
    chk("rst_digits", digs, 16'h0000);
    chk("rst_ocupado", 16'(ocupado), 16'h0);
    reset = 1'b1;
    step(1);

    // Drip run to completion.
    start(2'b01, 3'b001);
    chk("t1_estado", 16'(estado), 16'h2);
    chk("t1_got", 16'(gotejamento), 16'h1);
    chk("t1_load", digs, 16'h0300);
    tick();
    chk("t1_259", digs, 16'h0259);
    p0 = pulses;
    ticks(179);
    chk("t1_pulse", 16'(pulses - p0), 16'h1);
    chk("t1_end", digs, 16'h0000);
    chk("t1_idle", 16'(estado), 16'h0);
    chk("t1_got_off", 16'(gotejamento), 16'h0);

    // Sprinkler run and borrow chain.
    start(2'b00, 3'b011);
    chk("t2_load", digs, 16'h5100);
    chk("t2_asp", 16'(aspersao), 16'h1);
    ticks(60);
    chk("t2_5000", digs, 16'h5000);
    tick();
    chk("t2_4959", digs, 16'h4959);
    chk("t2_asp2", 16'(aspersao), 16'h1);
    ticks(589);
    chk("t2_4010", digs, 16'h4010);

    // Pause on low tank, then resume.
    nivelDagua = 3'b001;
    step(1);
    chk("t3_pausa", 16'(estado), 16'h3);
    chk("t3_asp_off", 16'(aspersao), 16'h0);
    chk("t3_alarm", 16'(alarmeAgua), 16'h1);
    ticks(20);
    chk("t3_frozen", digs, 16'h4010);
    nivelDagua = 3'b011;
    step(1);
    chk("t3_resume", 16'(estado), 16'h2);
    chk("t3_alarm_off", 16'(alarmeAgua), 16'h0);
    tick();
    chk("t3_4009", digs, 16'h4009);
    ticks(9);
    chk("t3_4000", digs, 16'h4000);
    tick();
    chk("t3_3959", digs, 16'h3959);
    cancel();
    chk("t3_cancel", digs, 16'h0000);

    // Wet soil: start ignored.
    umidade = 2'b10;
    iniciar = 1'b1;
    step(10);
    chk("t4_estado", 16'(estado), 16'h0);
    chk("t4_ocupado", 16'(ocupado), 16'h0);
    chk("t4_valves", 16'({aspersao, gotejamento}), 16'h0);
    iniciar = 1'b0;
    step(1);

    // Cancel coincident with the final tick.
    start(2'b01, 3'b001);
    ticks(179);
    chk("t5_0001", digs, 16'h0001);
    p0 = pulses;
    cancelar = 1'b1;
    umSegundo = 1'b1;
    step(1);
    cancelar = 1'b0;
    umSegundo = 1'b0;
    chk("t5_idle", 16'(estado), 16'h0);
    chk("t5_digits", digs, 16'h0000);
    step(3);
    chk("t5_nopulse", 16'(pulses - p0), 16'h0);

    // Alarm on a start the tank cannot serve.
    umidade = 2'b00;
    nivelDagua = 3'b001;
    iniciar = 1'b1;
    #1;
    chk("t7_alarm", 16'(alarmeAgua), 16'h1);
    step(1);
    iniciar = 1'b0;
    step(1);
    chk("t7_pausa", 16'(estado), 16'h3);
    cancel();

    // Asynchronous reset mid-drip.
    start(2'b01, 3'b001);
    ticks(90);
    chk("t6_0130", digs, 16'h0130);
    #1 reset = 1'b0;
    #1;
    chk("t6_digits", digs, 16'h0000);
    chk("t6_estado", 16'(estado), 16'h0);
    chk("t6_got", 16'(gotejamento), 16'h0);
    step(2);
    reset = 1'b1;
    step(2);
    chk("t6_idle", 16'(estado), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
